// File: rtl/alu_bus_ctrl_if.sv
// Control-unit/ALU side signal bundle for alu_bus_ctrl; the shared tristate data bus stays a plain inout.
// slave = the sequencer itself, master = the control unit / environment that drives commands and the ALU.
interface alu_bus_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 4
);
  logic              cmd_valid;
  logic [MODE_W-1:0] cmd_mode;
  logic              cmd_ready;
  logic              cmd_abort;
  logic              bus_valid;
  logic              rd_en;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [MODE_W-1:0] alu_mode;
  logic              alu_ee;
  logic              alu_eo;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zero;
  logic              alu_carry;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              flag_z;
  logic              flag_c;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_abort, bus_valid, rd_en,
    input  alu_out, alu_zero, alu_carry,
    output cmd_ready, alu_a, alu_b, alu_mode, alu_ee, alu_eo,
    output busy, done, result, flag_z, flag_c
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_abort, bus_valid, rd_en,
    output alu_out, alu_zero, alu_carry,
    input  cmd_ready, alu_a, alu_b, alu_mode, alu_ee, alu_eo,
    input  busy, done, result, flag_z, flag_c
  );
endinterface

// File: rtl/alu_bus_ctrl.sv
// Bus-side sequencer for the 8-bit combinational ALU: loads operands from the shared bus,
// strobes the ALU, captures result/flags and drives the result back onto the bus on request.
module alu_bus_ctrl #(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_bus_ctrl_if.slave    ifc,
  inout  wire [WIDTH-1:0]  bus,
  output logic [2:0]       dbg_state
);

  localparam logic [MODE_W-1:0] ALU_INC  = MODE_W'(5);
  localparam logic [MODE_W-1:0] ALU_DEC  = MODE_W'(6);
  localparam logic [MODE_W-1:0] ALU_SQRT = MODE_W'(7);
  localparam logic [MODE_W-1:0] ALU_ROL  = MODE_W'(8);
  localparam logic [MODE_W-1:0] ALU_ROR  = MODE_W'(9);
  localparam logic [MODE_W-1:0] ALU_NOT  = MODE_W'(10);
  localparam logic [3:0]        SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    EXEC    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       unary;
  logic       abort_hit;
  logic       bus_oe;

  // Handshake: a command is taken on any edge where cmd_valid && cmd_ready; operands are
  // taken on any edge in LOAD_A/LOAD_B where bus_valid is high. There is no back-pressure beyond that.
  assign unary     = ifc.alu_mode inside {ALU_INC, ALU_DEC, ALU_SQRT, ALU_ROL, ALU_ROR, ALU_NOT};
  assign abort_hit = ifc.cmd_abort && (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ifc.cmd_valid) state_nxt = LOAD_A;
      LOAD_A:  if (ifc.bus_valid) state_nxt = unary ? EXEC : LOAD_B;
      LOAD_B:  if (ifc.bus_valid) state_nxt = EXEC;
      EXEC:    if (settle_cnt == 4'd0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      ifc.alu_a    <= '0;
      ifc.alu_b    <= '0;
      ifc.alu_mode <= '0;
      ifc.result   <= '0;
      ifc.flag_z   <= 1'b0;
      ifc.flag_c   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!abort_hit) begin
        case (state)
          IDLE: if (ifc.cmd_valid) ifc.alu_mode <= ifc.cmd_mode;
          LOAD_A: begin
            if (ifc.bus_valid) begin
              ifc.alu_a  <= bus;
              settle_cnt <= SETTLE_M1;
              if (unary) ifc.alu_b <= '0;
            end
          end
          LOAD_B: begin
            if (ifc.bus_valid) begin
              ifc.alu_b  <= bus;
              settle_cnt <= SETTLE_M1;
            end
          end
          EXEC: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
          CAPTURE: begin
            ifc.result <= ifc.alu_out;
            ifc.flag_z <= ifc.alu_zero;
            ifc.flag_c <= ifc.alu_carry;
          end
          default: ;
        endcase
      end
    end
  end

  assign ifc.cmd_ready = (state == IDLE);
  assign ifc.busy      = (state != IDLE);
  assign ifc.alu_ee    = (state == EXEC) || (state == CAPTURE);
  assign ifc.alu_eo    = (state == CAPTURE);
  assign ifc.done      = (state == DONE);
  assign dbg_state     = state;

  // A simultaneous command wins over a read so the bus is never contended on acceptance.
  assign bus_oe = (state == IDLE) && ifc.rd_en && !ifc.cmd_valid;
  assign bus    = bus_oe ? ifc.result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_bus_ctrl.sv
// Self-checking bench for alu_bus_ctrl: directed scenarios plus randomized operations against a reference model.
module tb_alu_bus_ctrl;
  localparam int SETTLE = 1;
  localparam logic [3:0] M_ADD = 4'd0, M_SUB = 4'd1, M_XOR = 4'd4, M_INC = 4'd5;

  logic       clk;
  logic       rst_n;
  logic [7:0] drv;
  logic       drv_en;
  logic [2:0] dbg_state;
  tri1  [7:0] bus;
  int         checks;
  int         failures;
  logic [9:0] exp_q[$];

  alu_bus_ctrl_if #(.WIDTH(8), .MODE_W(4)) ifc ();

  alu_bus_ctrl #(.WIDTH(8), .MODE_W(4), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .ifc(ifc), .bus(bus), .dbg_state(dbg_state)
  );

  assign bus = drv_en ? drv : 8'hzz;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // reference ALU: {carry, result}
  function automatic logic [8:0] ref_alu(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = {1'b0, a};
    case (m)
      4'd0: r = {1'b0, a} + {1'b0, b};
      4'd1: r = {1'b0, a} - {1'b0, b};
      4'd2: r = {1'b0, a & b};
      4'd3: r = {1'b0, a | b};
      4'd4: r = {1'b0, a ^ b};
      4'd5: r = {1'b0, a} + 9'd1;
      4'd6: r = {1'b0, a} - 9'd1;
      4'd7: begin
        r = 9'd0;
        for (int i = 0; i < 16; i++) if (i * i <= int'(a)) r = 9'(i);
      end
      4'd8: r = {a[7], a[6:0], a[7]};
      4'd9: r = {a[0], a[0], a[7:1]};
      4'd10: r = {1'b0, ~a};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic bit is_unary_ref(input logic [3:0] m);
    return (m >= 4'd5) && (m <= 4'd10);
  endfunction

  // environment ALU: only presents a meaningful value while both enables are up
  always_comb begin
    logic [8:0] r;
    r = ref_alu(ifc.alu_mode, ifc.alu_a, ifc.alu_b);
    if (ifc.alu_ee && ifc.alu_eo) begin
      ifc.alu_out   = r[7:0];
      ifc.alu_zero  = (r[7:0] == 8'h00);
      ifc.alu_carry = r[8];
    end else begin
      ifc.alu_out   = 8'hEE;
      ifc.alu_zero  = 1'b0;
      ifc.alu_carry = 1'b0;
    end
  end

  // driver: one full operation, returns observations
  task automatic run_op(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b,
                        input int gap_a, input int gap_b, input bit noise,
                        output int exp_k, output int done_k, output int done_cnt, output int ee_cnt,
                        output int eo_cnt, output int busy_err, output int bus_err,
                        output logic [7:0] a_seen, output logic [7:0] b_seen, output logic [3:0] mode_seen);
    int a_edge, b_edge;
    a_edge = 1 + gap_a;
    b_edge = a_edge + 1 + gap_b;
    exp_k  = (is_unary_ref(mode) ? a_edge : b_edge) + SETTLE + 1;
    done_k = -1; done_cnt = 0; ee_cnt = 0; eo_cnt = 0; busy_err = 0; bus_err = 0;
    a_seen = 8'hEE; b_seen = 8'hEE; mode_seen = 4'hF;
    ifc.cmd_mode = mode; ifc.cmd_valid = 1'b1; ifc.bus_valid = 1'b0; ifc.rd_en = 1'b0; drv_en = 1'b0;
    for (int k = 0; k <= exp_k + 1; k++) begin
      @(negedge clk);
      if (ifc.done) begin done_cnt++; done_k = k; end
      if (ifc.alu_ee) ee_cnt++;
      if (ifc.alu_eo) begin
        eo_cnt++; a_seen = ifc.alu_a; b_seen = ifc.alu_b; mode_seen = ifc.alu_mode;
      end
      if (ifc.busy !== (k <= exp_k)) busy_err++;
      if (!drv_en && bus !== 8'hFF) bus_err++;
      ifc.cmd_valid = noise && (k < exp_k);
      ifc.rd_en     = noise && (k < exp_k);
      if (noise) ifc.cmd_mode = ~mode;
      if (k + 1 == a_edge) begin
        ifc.bus_valid = 1'b1; drv_en = 1'b1; drv = a;
      end else if (k + 1 == b_edge) begin
        ifc.bus_valid = 1'b1; drv_en = 1'b1; drv = b;
      end else begin
        ifc.bus_valid = 1'b0; drv_en = 1'b0; drv = 8'h00;
      end
    end
    ifc.cmd_valid = 1'b0; ifc.rd_en = 1'b0; ifc.bus_valid = 1'b0; drv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", ifc.busy, ifc.done); end
    checks++; if (ifc.alu_ee !== 1'b0 || ifc.alu_eo !== 1'b0) begin failures++; $display("FAIL reset_ee_eo got=%b%b exp=00", ifc.alu_ee, ifc.alu_eo); end
    checks++; if ({ifc.alu_a, ifc.alu_b, ifc.result} !== 24'h0 || ifc.alu_mode !== 4'h0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h/%h exp=0", ifc.alu_a, ifc.alu_b, ifc.result, ifc.alu_mode); end
    checks++; if ({ifc.flag_z, ifc.flag_c} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ifc.flag_z, ifc.flag_c); end
    checks++; if (bus !== 8'hFF) begin failures++; $display("FAIL reset_bus got=%h exp=ff(Z)", bus); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifc.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ifc.cmd_ready); end
  endtask

  task automatic test_add_basic();
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_ADD, 8'h3C, 8'h14, 0, 0, 1'b0, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (dc !== 1 || dk !== 4) begin failures++; $display("FAIL add_done_time got=%0d@%0d exp=1@4", dc, dk); end
    checks++; if (ee !== 2 || eo !== 1) begin failures++; $display("FAIL add_enables got=ee%0d eo%0d exp=ee2 eo1", ee, eo); end
    checks++; if (as !== 8'h3C || bs !== 8'h14 || ms !== M_ADD) begin failures++; $display("FAIL add_operands got=%h %h %h exp=3c 14 0", as, bs, ms); end
    checks++; if (ifc.result !== 8'h50 || ifc.flag_z !== 1'b0 || ifc.flag_c !== 1'b0) begin failures++; $display("FAIL add_result got=%h z%b c%b exp=50 z0 c0", ifc.result, ifc.flag_z, ifc.flag_c); end
    checks++; if (be !== 0 || ue !== 0) begin failures++; $display("FAIL add_busy_bus got=%0d %0d exp=0 0", be, ue); end
  endtask

  task automatic test_add_carry();
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_ADD, 8'hFF, 8'h01, 0, 0, 1'b0, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (ifc.result !== 8'h00 || ifc.flag_z !== 1'b1 || ifc.flag_c !== 1'b1) begin failures++; $display("FAIL carry_result got=%h z%b c%b exp=00 z1 c1", ifc.result, ifc.flag_z, ifc.flag_c); end
    ifc.rd_en = 1'b1;
    #1;
    checks++; if (bus !== 8'h00) begin failures++; $display("FAIL carry_readback got=%h exp=00", bus); end
    @(negedge clk);
    ifc.rd_en = 1'b0;
    #1;
    checks++; if (bus !== 8'hFF) begin failures++; $display("FAIL carry_read_release got=%h exp=ff(Z)", bus); end
  endtask

  task automatic test_unary_inc();
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_INC, 8'h7F, 8'hAA, 0, 0, 1'b0, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (dc !== 1 || dk !== 3) begin failures++; $display("FAIL inc_done_time got=%0d@%0d exp=1@3", dc, dk); end
    checks++; if (as !== 8'h7F || bs !== 8'h00) begin failures++; $display("FAIL inc_operands got=%h %h exp=7f 00", as, bs); end
    checks++; if (ifc.result !== 8'h80 || ifc.flag_z !== 1'b0 || ifc.flag_c !== 1'b0) begin failures++; $display("FAIL inc_result got=%h z%b c%b exp=80 z0 c0", ifc.result, ifc.flag_z, ifc.flag_c); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL inc_extra_pulse got=busy%b exp=busy0", ifc.busy); end
  endtask

  task automatic test_load_wait();
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_SUB, 8'h10, 8'h20, 0, 5, 1'b0, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (be !== 0 || ee !== 2) begin failures++; $display("FAIL wait_busy_ee got=%0d ee%0d exp=0 ee2", be, ee); end
    checks++; if (dc !== 1 || dk !== 9) begin failures++; $display("FAIL wait_done_time got=%0d@%0d exp=1@9", dc, dk); end
    checks++; if (ifc.result !== 8'hF0 || ifc.flag_z !== 1'b0 || ifc.flag_c !== 1'b1) begin failures++; $display("FAIL sub_result got=%h z%b c%b exp=f0 z0 c1", ifc.result, ifc.flag_z, ifc.flag_c); end
  endtask

  task automatic test_abort();
    int ek, dk, dc, ee, eo, be, ue, seen; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_ADD, 8'h3C, 8'h14, 0, 0, 1'b0, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (ifc.result !== 8'h50) begin failures++; $display("FAIL abort_prior got=%h exp=50", ifc.result); end
    // abort in LOAD_B
    ifc.cmd_valid = 1'b1; ifc.cmd_mode = M_XOR; ifc.bus_valid = 1'b1; drv_en = 1'b1; drv = 8'h0F;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    ifc.bus_valid = 1'b0; drv_en = 1'b0;
    checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", ifc.busy); end
    ifc.cmd_abort = 1'b1;
    @(negedge clk);
    ifc.cmd_abort = 1'b0;
    checks++; if (ifc.busy !== 1'b0 || ifc.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=busy%b rdy%b exp=busy0 rdy1", ifc.busy, ifc.cmd_ready); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (ifc.done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    checks++; if (ifc.result !== 8'h50 || ifc.flag_z !== 1'b0 || ifc.flag_c !== 1'b0) begin failures++; $display("FAIL abort_hold got=%h z%b c%b exp=50 z0 c0", ifc.result, ifc.flag_z, ifc.flag_c); end
    // command and read together: command wins, bus stays Z
    ifc.cmd_valid = 1'b1; ifc.rd_en = 1'b1; ifc.cmd_mode = M_ADD;
    #1;
    checks++; if (bus !== 8'hFF) begin failures++; $display("FAIL cmd_rd_bus got=%h exp=ff(Z)", bus); end
    @(negedge clk);
    ifc.cmd_valid = 1'b0; ifc.rd_en = 1'b0;
    checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL cmd_rd_accept got=%b exp=1", ifc.busy); end
    ifc.cmd_abort = 1'b1;
    @(negedge clk);
    ifc.cmd_abort = 1'b0;
    // abort during EXEC drops the enables
    ifc.cmd_valid = 1'b1; ifc.cmd_abort = 1'b1; ifc.cmd_mode = M_ADD; ifc.bus_valid = 1'b1; drv_en = 1'b1; drv = 8'h22;
    @(negedge clk);
    ifc.cmd_valid = 1'b0; ifc.cmd_abort = 1'b0;
    checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL abort_in_idle got=%b exp=1", ifc.busy); end
    @(negedge clk);
    @(negedge clk);
    ifc.bus_valid = 1'b0; drv_en = 1'b0;
    checks++; if (ifc.alu_ee !== 1'b1) begin failures++; $display("FAIL exec_ee got=%b exp=1", ifc.alu_ee); end
    ifc.cmd_abort = 1'b1;
    @(negedge clk);
    ifc.cmd_abort = 1'b0;
    checks++; if ({ifc.alu_ee, ifc.alu_eo, ifc.busy, ifc.done} !== 4'b0000) begin failures++; $display("FAIL exec_abort got=%b exp=0000", {ifc.alu_ee, ifc.alu_eo, ifc.busy, ifc.done}); end
    checks++; if (ifc.result !== 8'h50) begin failures++; $display("FAIL exec_abort_hold got=%h exp=50", ifc.result); end
  endtask

  task automatic test_reset_mid_op();
    ifc.cmd_valid = 1'b1; ifc.cmd_mode = M_ADD; ifc.bus_valid = 1'b1; drv_en = 1'b1; drv = 8'h3C;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    drv = 8'h14;
    @(negedge clk);
    ifc.bus_valid = 1'b0; drv_en = 1'b0;
    checks++; if (ifc.alu_ee !== 1'b1) begin failures++; $display("FAIL rst_mid_exec got=%b exp=1", ifc.alu_ee); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ifc.alu_ee, ifc.alu_eo, ifc.busy, ifc.done} !== 4'b0000) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {ifc.alu_ee, ifc.alu_eo, ifc.busy, ifc.done}); end
    checks++; if ({ifc.alu_a, ifc.alu_b, ifc.result, ifc.flag_z, ifc.flag_c} !== 26'h0) begin failures++; $display("FAIL rst_mid_regs got=%h %h %h exp=0", ifc.alu_a, ifc.alu_b, ifc.result); end
    checks++; if (bus !== 8'hFF) begin failures++; $display("FAIL rst_mid_bus got=%h exp=ff(Z)", bus); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=rdy%b busy%b exp=rdy1 busy0", ifc.cmd_ready, ifc.busy); end
  endtask

  task automatic test_random(input int n);
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs, a, b; logic [3:0] ms, m;
    logic [8:0] r; logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      m = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      r = ref_alu(m, a, is_unary_ref(m) ? 8'h00 : b);
      exp_q.push_back({r[8], r[7:0] == 8'h00, r[7:0]});
      run_op(m, a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ek, dk, dc, ee, eo, be, ue, as, bs, ms);
      e = exp_q.pop_front();
      checks++; if (dc !== 1 || dk !== ek) begin failures++; $display("FAIL rnd_done op%0d got=%0d@%0d exp=1@%0d", i, dc, dk, ek); end
      checks++; if (ee !== SETTLE + 1 || eo !== 1 || be !== 0 || ue !== 0) begin failures++; $display("FAIL rnd_ctrl op%0d got=ee%0d eo%0d busy%0d bus%0d exp=ee%0d eo1 0 0", i, ee, eo, be, ue, SETTLE + 1); end
      checks++; if (as !== a || bs !== (is_unary_ref(m) ? 8'h00 : b) || ms !== m) begin failures++; $display("FAIL rnd_operands op%0d got=%h %h %h exp=%h %h %h", i, as, bs, ms, a, is_unary_ref(m) ? 8'h00 : b, m); end
      checks++; if ({ifc.flag_c, ifc.flag_z, ifc.result} !== e) begin failures++; $display("FAIL rnd_result op%0d got=%h exp=%h", i, {ifc.flag_c, ifc.flag_z, ifc.result}, e); end
      ifc.rd_en = 1'b1;
      #1;
      checks++; if (bus !== e[7:0]) begin failures++; $display("FAIL rnd_readback op%0d got=%h exp=%h", i, bus, e[7:0]); end
      ifc.rd_en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int ek, dk, dc, ee, eo, be, ue; logic [7:0] as, bs; logic [3:0] ms;
    run_op(M_SUB, 8'h05, 8'h03, 0, 0, 1'b1, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (ifc.result !== 8'h02 || ifc.flag_c !== 1'b0 || ms !== M_SUB) begin failures++; $display("FAIL b2b_first got=%h c%b m%h exp=02 c0 m1", ifc.result, ifc.flag_c, ms); end
    run_op(M_XOR, 8'hA5, 8'hA5, 0, 0, 1'b1, ek, dk, dc, ee, eo, be, ue, as, bs, ms);
    checks++; if (ifc.result !== 8'h00 || ifc.flag_z !== 1'b1 || dk !== 4 || be !== 0 || ue !== 0) begin failures++; $display("FAIL b2b_second got=%h z%b @%0d %0d %0d exp=00 z1 @4 0 0", ifc.result, ifc.flag_z, dk, be, ue); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; drv = 8'h00; drv_en = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_mode = 4'h0; ifc.cmd_abort = 1'b0; ifc.bus_valid = 1'b0; ifc.rd_en = 1'b0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_unary_inc();
    test_load_wait();
    test_abort();
    test_reset_mid_op();
    test_random(24);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_bus_ctrl.md
Name: alu_bus_ctrl

Overview:
- Bus-side sequencer that drives the 8-bit ALU as its initiator.
- Accepts an operation command and pulls one or two operands off the shared 8-bit data bus.
- Drives the ALU operand, mode and enable lines, then captures the ALU result and zero/carry flags into registers.
- Drives the captured result back onto the shared bus on request.
- Sits between the control unit/bus and the combinational ALU, and replaces ad-hoc operand/result registers.

Parameters:
- WIDTH, 8, data/bus width.
- MODE_W, 4, ALU mode width; codes come from symbols.vh.
- SETTLE, 1, cycles alu_ee is held before alu_eo is asserted; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_mode  input  MODE_W  ALU operation code.
- cmd_ready  output  1  high only in IDLE.
- cmd_abort  input  1  return to IDLE from any state.
- bus_valid  input  1  operand present on bus this cycle.
- rd_en  input  1  request to drive the stored result onto the bus.
- bus  inout  WIDTH  shared data bus.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_mode  output  MODE_W  ALU mode.
- alu_ee  output  1  ALU evaluate enable.
- alu_eo  output  1  ALU output enable.
- alu_out  input  WIDTH  ALU result (ALU-driven tristate net).
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is captured.
- result  output  WIDTH  last captured result.
- flag_z  output  1  captured zero flag.
- flag_c  output  1  captured carry flag.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - alu_a, alu_b, alu_mode, result = 0; flag_z, flag_c = 0.
  - alu_ee, alu_eo, done, busy = 0; bus = high-Z.
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DONE.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid=1 latches cmd_mode into alu_mode and moves to LOAD_A.
  - rd_en=1 with cmd_valid=0 drives result onto bus this cycle (combinational output enable); otherwise bus = Z.
  - cmd_valid and rd_en together: command accepted, bus stays Z.
- LOAD_A:
  - Waits indefinitely for bus_valid, then latches bus into alu_a.
  - Unary modes (ALU_INC, ALU_DEC, ALU_SQRT, ALU_ROL, ALU_ROR, ALU_NOT): alu_b = 0, go to EXEC.
  - All other modes: go to LOAD_B.
- LOAD_B: waits for bus_valid, latches bus into alu_b, goes to EXEC.
- EXEC:
  - alu_ee = 1 for exactly SETTLE cycles (internal down-counter), then go to CAPTURE.
- CAPTURE (one cycle):
  - alu_ee = 1 and alu_eo = 1.
  - At the clock edge, alu_out goes to result, alu_zero to flag_z, alu_carry to flag_c.
  - Go to DONE.
- DONE (one cycle):
  - done = 1; alu_ee = alu_eo = 0; go to IDLE.
- Bus rule: this block never drives bus while alu_eo=1 or in any state except IDLE with rd_en.
- Latency, with bus_valid already high and SETTLE=1:
  - Command accepted at edge T.
  - A latched T+1, B latched T+2, capture edge T+4, done high in cycle T+4→T+5.
  - Unary operations are one cycle shorter.
- cmd_valid outside IDLE is ignored; no queueing.
- rd_en outside IDLE is ignored.
- cmd_abort:
  - Highest priority; goes to IDLE next edge.
  - alu_ee and alu_eo drop.
  - result and flags unchanged; no done pulse.
  - In IDLE it has no effect.
- Unknown mode codes are passed through unchanged. Captured values are whatever the ALU presents; no X-filtering.
- result and flags hold until the next successful CAPTURE.

Test Plan:
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0, bus=Z, busy=0 immediately. After release, cmd_ready=1.
- ALU_ADD, operands 0x3C then 0x14, bus_valid continuous → done at T+4. result=0x50, flag_z=0, flag_c=0. alu_ee high for 2 cycles total.
- ALU_ADD, operands 0xFF, 0x01 → result=0x00, flag_z=1, flag_c=1. Then rd_en in IDLE → bus=0x00 for that cycle only.
- ALU_INC, operand 0x7F → only one bus_valid consumed, alu_b=0, result=0x80, done at T+3. A second bus_valid pulse is ignored.
- ALU_SUB with bus_valid withheld 5 cycles in LOAD_B → stays in LOAD_B with busy=1. Then operands 0x10, 0x20 → result=0xF0, flag_c=1.
- Prior result 0x50; start ALU_XOR, assert cmd_abort in LOAD_B → IDLE next cycle, no done pulse, result stays 0x50. cmd_valid+rd_en same cycle → command accepted, bus=Z.
